sflash_seq: RTL and testbench

SFLASH_SEQ -- requirements
Module: sflash_seq

---
 rtl/sflash_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_sflash_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sflash_seq.sv
// sflash_seq: two-requester round-robin read sequencer driving a serial-flash byte engine.
module sflash_seq (
  input  logic        clk,
  input  logic        arstn,
  input  logic        quad,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        rlast,
  output logic        rid,
  output logic        busy,
  input  logic        f_ready,
  output logic        f_wr,
  output logic [7:0]  f_din,
  output logic [2:0]  f_format,
  input  logic [7:0]  f_dout
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 9;
  localparam int unsigned FW = 3;

  localparam logic [FW-1:0] FMT_OFF  = 3'b000;
  localparam logic [FW-1:0] FMT_SDR  = 3'b010;
  localparam logic [FW-1:0] FMT_QUAD = 3'b111;
  localparam logic [DW-1:0] CMD_READ  = 8'h03;
  localparam logic [DW-1:0] CMD_QREAD = 8'h6B;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          quad_q, quad_d;
  logic          rid_q, rid_d;
  logic          pend_q, pend_d;
  logic [1:0]    guard_q, guard_d;
  logic [1:0]    idx_q, idx_d;
  logic          gap_q, gap_d;
  logic          f_wr_q, f_wr_d;
  logic [DW-1:0] f_din_q, f_din_d;
  logic [FW-1:0] f_format_q, f_format_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rlast_q, rlast_d;
  logic          busy_q, busy_d;

  logic          pick;
  logic [DW-1:0] sel_len;
  logic          done;
  logic          can_issue;

  // Byte completes once the two-cycle guard after f_wr has elapsed and the engine is ready.
  assign done      = pend_q && (guard_q == 2'd0) && f_ready;
  assign can_issue = f_ready && (guard_q == 2'd0) && !f_wr_q;

  // Next-state, arbitration, byte issue and response generation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    quad_d     = quad_q;
    rid_d      = rid_q;
    pend_d     = pend_q;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    f_wr_d     = 1'b0;
    f_din_d    = f_din_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    rlast_d    = 1'b0;
    pick       = 1'b0;
    sel_len    = len0;

    if (done) pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          pick    = (req0 && req1) ? ptr_q : req1;
          sel_len = pick ? len1 : len0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          ptr_d   = ~pick;
          addr_d  = pick ? addr1 : addr0;
          cnt_d   = (sel_len == 8'd0) ? 9'd256 : CW'(sel_len);
          quad_d  = quad;
          rid_d   = pick;
          idx_d   = 2'd0;
          pend_d  = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (done) begin
          state_d = S_ADDR;
          idx_d   = 2'd0;
        end
      end
      S_ADDR: begin
        if (done) begin
          if (idx_q == 2'd2) state_d = quad_q ? S_DUMMY : S_DATA;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      S_DUMMY: begin
        if (done) state_d = S_DATA;
      end
      S_DATA: begin
        if (done) begin
          rvalid_d = 1'b1;
          rdata_d  = f_dout;
          rlast_d  = (cnt_q == 9'd1);
          cnt_d    = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_GAP;
            gap_d   = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (gap_q) state_d = S_IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (can_issue && (state_q != S_IDLE)) begin
      case (state_d)
        S_CMD: begin
          f_wr_d  = 1'b1;
          f_din_d = quad_q ? CMD_QREAD : CMD_READ;
        end
        S_ADDR: begin
          f_wr_d = 1'b1;
          case (idx_d)
            2'd0:    f_din_d = addr_q[23:16];
            2'd1:    f_din_d = addr_q[15:8];
            default: f_din_d = addr_q[7:0];
          endcase
        end
        S_DUMMY, S_DATA: begin
          f_wr_d  = 1'b1;
          f_din_d = 8'h00;
        end
        default: f_wr_d = 1'b0;
      endcase
      if (f_wr_d) begin
        pend_d  = 1'b1;
        guard_d = 2'd2;
      end
    end

    case (state_d)
      S_CMD, S_ADDR, S_DUMMY: f_format_d = FMT_SDR;
      S_DATA:                 f_format_d = quad_d ? FMT_QUAD : FMT_SDR;
      default:                f_format_d = FMT_OFF;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      quad_q     <= 1'b0;
      rid_q      <= 1'b0;
      pend_q     <= 1'b0;
      guard_q    <= 2'd0;
      idx_q      <= 2'd0;
      gap_q      <= 1'b0;
      f_wr_q     <= 1'b0;
      f_din_q    <= '0;
      f_format_q <= FMT_OFF;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      quad_q     <= quad_d;
      rid_q      <= rid_d;
      pend_q     <= pend_d;
      guard_q    <= guard_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      f_wr_q     <= f_wr_d;
      f_din_q    <= f_din_d;
      f_format_q <= f_format_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rlast    = rlast_q;
  assign rid      = rid_q;
  assign busy     = busy_q;
  assign f_wr     = f_wr_q;
  assign f_din    = f_din_q;
  assign f_format = f_format_q;

endmodule

// File: tb/tb_sflash_seq.sv
// tb_sflash_seq: random requests against a flash/byte-engine model with queue scoreboards.
module tb_sflash_seq;

  logic        clk = 1'b0;
  logic        arstn, quad, req0, req1;
  logic [23:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic        gnt0, gnt1, rvalid, rlast, rid, busy;
  logic [7:0]  rdata;
  logic        f_ready, f_wr;
  logic [7:0]  f_din, f_dout;
  logic [2:0]  f_format;

  sflash_seq dut (
    .clk(clk), .arstn(arstn), .quad(quad), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
    .rid(rid), .busy(busy), .f_ready(f_ready), .f_wr(f_wr), .f_din(f_din),
    .f_format(f_format), .f_dout(f_dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] fmt;
    logic       is_data;
    logic [7:0] dat;
  } tx_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       id;
  } rx_t;

  tx_t  exp_tx[$];
  rx_t  exp_rx[$];
  logic gorder[$];

  int checks = 0;
  int fails  = 0;
  int dly_lo = 1;
  int dly_hi = 4;
  int rv_seen = 0;
  logic rr_ptr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flash contents as a pure function of the byte address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Byte engine: takes a byte on f_wr, returns after a random delay with flash data.
  int         ecnt = 0;
  bit         ebusy = 1'b0;
  logic [7:0] enext = 8'h00;
  always @(posedge clk) begin
    tx_t t;
    if (!arstn) begin
      f_ready <= 1'b1;
      f_dout  <= 8'h00;
      ebusy = 1'b0;
      ecnt  = 0;
    end else if (f_wr) begin
      check("eng_idle_at_wr", 32'(ebusy), 32'd0);
      checks++;
      if (exp_tx.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: f_wr with din %0h, none expected", f_din);
        enext = 8'h00;
      end else begin
        t = exp_tx.pop_front();
        check("tx_din", 32'(f_din), 32'(t.din));
        check("tx_fmt", 32'(f_format), 32'(t.fmt));
        enext = t.is_data ? t.dat : 8'($urandom);
      end
      f_ready <= 1'b0;
      ebusy = 1'b1;
      ecnt  = $urandom_range(dly_hi, dly_lo);
    end else if (ebusy) begin
      ecnt--;
      if (ecnt <= 0) begin
        f_ready <= 1'b1;
        f_dout  <= enext;
        ebusy = 1'b0;
      end
    end
  end

  // Monitor: arbitration model, expectation push at grant, response and CS-gap checks.
  initial begin
    bit in_burst = 1'b0;
    int gap_ph = 0;
    int gap_nx;
    forever begin
      @(posedge clk);
      #1;
      if (!arstn) begin
        in_burst = 1'b0;
        gap_ph   = 0;
        continue;
      end
      gap_nx = 0;
      if (gap_ph == 1) begin
        check("gap1_busy", 32'(busy), 32'd1);
        check("gap1_fmt", 32'(f_format), 32'd0);
        gap_nx = 2;
      end else if (gap_ph == 2) begin
        check("gap_end_busy", 32'(busy), 32'd0);
      end
      if (gnt0 || gnt1) begin
        logic es, q;
        logic [23:0] a;
        logic [7:0] l, dd;
        int n;
        check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        check("gnt_had_req", 32'(req0 | req1), 32'd1);
        check("gnt_not_in_burst", 32'(in_burst), 32'd0);
        es = (req0 && req1) ? rr_ptr : req1;
        check("gnt_side", 32'(gnt1), 32'(es));
        check("busy_at_gnt", 32'(busy), 32'd1);
        rr_ptr = ~es;
        gorder.push_back(gnt1);
        a = gnt1 ? addr1 : addr0;
        l = gnt1 ? len1 : len0;
        q = quad;
        n = (l == 8'd0) ? 256 : int'(l);
        exp_tx.push_back('{din: q ? 8'h6B : 8'h03, fmt: 3'b010, is_data: 1'b0, dat: 8'h00});
        exp_tx.push_back('{din: a[23:16], fmt: 3'b010, is_data: 1'b0, dat: 8'h00});
        exp_tx.push_back('{din: a[15:8],  fmt: 3'b010, is_data: 1'b0, dat: 8'h00});
        exp_tx.push_back('{din: a[7:0],   fmt: 3'b010, is_data: 1'b0, dat: 8'h00});
        if (q) exp_tx.push_back('{din: 8'h00, fmt: 3'b010, is_data: 1'b0, dat: 8'h00});
        for (int i = 0; i < n; i++) begin
          dd = mem_byte(a + 24'(i));
          exp_tx.push_back('{din: 8'h00, fmt: q ? 3'b111 : 3'b010, is_data: 1'b1, dat: dd});
          exp_rx.push_back('{data: dd, last: (i == n - 1), id: gnt1});
        end
        in_burst = 1'b1;
      end
      if (in_burst && !(rvalid && rlast)) begin
        check("fmt_live_in_burst", 32'(f_format == 3'b000), 32'd0);
        check("busy_in_burst", 32'(busy), 32'd1);
      end
      if (rvalid) begin
        rx_t e;
        rv_seen++;
        checks++;
        if (exp_rx.size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected: rvalid with rdata %0h, none expected", rdata);
        end else begin
          e = exp_rx.pop_front();
          check("rdata", 32'(rdata), 32'(e.data));
          check("rlast", 32'(rlast), 32'(e.last));
          check("rid", 32'(rid), 32'(e.id));
          if (rlast) begin
            check("fmt_off_after_last", 32'(f_format), 32'd0);
            in_burst = 1'b0;
            gap_nx = 1;
          end
        end
      end
      gap_ph = gap_nx;
    end
  end

  task automatic chk_reset_outputs();
    check("rst_f_wr", 32'(f_wr), 32'd0);
    check("rst_f_din", 32'(f_din), 32'd0);
    check("rst_f_format", 32'(f_format), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_req(input logic r0, input logic r1, input logic [23:0] a0,
                           input logic [23:0] a1, input logic [7:0] l0,
                           input logic [7:0] l1, input logic q);
    @(negedge clk);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; len0 = l0; len1 = l1; quad = q;
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  endtask

  // Drops each request on its grant and waits for all traffic to drain.
  task automatic wait_done(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (!req0 && !req1 && !busy && exp_rx.size() == 0 && exp_tx.size() == 0) break;
      n++;
      if (n > budget) begin
        checks++;
        fails++;
        $display("FAIL timeout: %0d cycles, %0d bytes outstanding", n, exp_rx.size());
        finish_run();
      end
    end
  endtask

  initial begin
    int base;
    int n;
    arstn = 1'b0; quad = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    arstn = 1'b1;

    // Basic SDR read and quad read.
    start_req(1, 0, 24'h123456, 24'h0, 8'd2, 8'd0, 1'b0);
    wait_done(2000);
    start_req(0, 1, 24'h0, 24'h000100, 8'd0, 8'd1, 1'b1);
    wait_done(2000);

    // Simultaneous requests, twice: expected order 0,1,0,1 after the first grants above.
    gorder.delete();
    start_req(1, 1, 24'hABCDEF, 24'h00FFFF, 8'd3, 8'd2, 1'b0);
    wait_done(4000);
    start_req(1, 1, 24'h010203, 24'h040506, 8'd1, 8'd4, 1'b1);
    wait_done(4000);
    check("order_count", 32'(gorder.size()), 32'd4);
    if (gorder.size() == 4) begin
      check("order0", 32'(gorder[0]), 32'd0);
      check("order1", 32'(gorder[1]), 32'd1);
      check("order2", 32'(gorder[2]), 32'd0);
      check("order3", 32'(gorder[3]), 32'd1);
    end

    // 256-byte burst.
    base = rv_seen;
    start_req(1, 0, 24'hFFFF80, 24'h0, 8'd0, 8'd0, 1'b0);
    wait_done(20000);
    check("len0_bytes", 32'(rv_seen - base), 32'd256);

    // Randomized traffic with short and long engine latencies.
    for (int it = 0; it < 24; it++) begin
      logic r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      if (it % 3 == 0) begin dly_lo = 3; dly_hi = 40; end
      else             begin dly_lo = 1; dly_hi = 4;  end
      start_req(r0, r1,
                (it % 5 == 0) ? 24'hFFFFFE : 24'($urandom),
                24'($urandom),
                8'($urandom_range(10, 1)), 8'($urandom_range(10, 1)),
                1'($urandom));
      wait_done(20000);
    end
    dly_lo = 1; dly_hi = 4;

    // Reset while byte 3 of an 8-byte burst is in flight.
    base = rv_seen;
    start_req(1, 0, 24'h200000, 24'h0, 8'd8, 8'd0, 1'b0);
    n = 0;
    while (rv_seen - base < 2) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      n++;
      if (n > 2000) begin
        checks++;
        fails++;
        $display("FAIL timeout_pre_reset: %0d bytes seen", rv_seen - base);
        finish_run();
      end
    end
    @(negedge clk);
    req0 = 1'b0;
    arstn = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    rr_ptr = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    gorder.delete();
    start_req(1, 1, 24'h300010, 24'h400020, 8'd3, 8'd2, 1'b1);
    wait_done(4000);
    check("post_rst_grants", 32'(gorder.size()), 32'd2);
    if (gorder.size() == 2) check("post_rst_first", 32'(gorder[0]), 32'd0);

    repeat (5) @(negedge clk);
    finish_run();
  end

endmodule
